// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operand width,
// funct3 operation codes and FSM state encoding.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } mdState_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift-add multiply step or one
// restoring-division step on the shared {high, low} accumulator.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              isDiv,
    output logic [2*XLEN-1:0] accNext
);

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] diffLo;
    logic            qBit;

    // Divide: high half is the partial remainder, low half shifts the dividend
    // out at the top while quotient bits enter at the bottom.
    always_comb begin
        shifted = acc[2*XLEN-1:XLEN-1];
        qBit    = (shifted >= {1'b0, operand});
        diffLo  = shifted[XLEN-1:0] - operand;
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand : {XLEN{1'b0}})};
        if (isDiv) begin
            accNext = {(qBit ? diffLo : shifted[XLEN-1:0]), acc[XLEN-2:0], qBit};
        end else begin
            accNext = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 iterations on magnitudes, then a
// sign fix and field select; divide-by-zero and overflow finish in one cycle.
module muldiv_unit #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    output logic            busy,
    output logic            done,
    output logic            stall,
    output logic [XLEN-1:0] result
);

    import muldiv_pkg::*;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    mdState_t          state, stateNext;
    logic [4:0]        cnt;
    logic [2:0]        funct3Reg;
    logic              resSign;
    logic [XLEN-1:0]   opReg;
    logic [2*XLEN-1:0] acc, accNext;

    logic            isDiv, signA, signB, divZero, divOvf;
    logic [XLEN-1:0] magA, magB;
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0] remFix, calcResult;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        isDiv   = funct3[2];
        signA   = operandA[XLEN-1] &&
                  (funct3 == MD_MULH || funct3 == MD_MULHSU || funct3 == MD_DIV || funct3 == MD_REM);
        signB   = operandB[XLEN-1] && (funct3 == MD_MULH || funct3 == MD_DIV || funct3 == MD_REM);
        magA    = signA ? -operandA : operandA;
        magB    = signB ? -operandB : operandB;
        divZero = isDiv && (operandB == '0);
        divOvf  = (funct3 == MD_DIV || funct3 == MD_REM) && (operandA == MIN_INT) && (operandB == ALL_ONES);
    end

    muldiv_step uStep (
        .acc     (acc),
        .operand (opReg),
        .isDiv   (funct3Reg[2]),
        .accNext (accNext)
    );

    always_comb begin
        prodFix = resSign ? -accNext : accNext;
        remFix  = resSign ? -accNext[2*XLEN-1:XLEN] : accNext[2*XLEN-1:XLEN];
        case (funct3Reg)
            MD_MUL:                      calcResult = prodFix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: calcResult = prodFix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             calcResult = prodFix[XLEN-1:0];
            default:                     calcResult = remFix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MD_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            MD_IDLE: if (start) stateNext = (divZero || divOvf) ? MD_DONE : MD_CALC;
            MD_CALC: if (cnt == 5'd31) stateNext = MD_DONE;
            default: stateNext = MD_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            funct3Reg <= '0;
            resSign   <= 1'b0;
            opReg     <= '0;
            acc       <= '0;
            result    <= '0;
        end else begin
            case (state)
                MD_IDLE: if (start) begin
                    cnt       <= '0;
                    funct3Reg <= funct3;
                    resSign   <= (funct3 == MD_REM || funct3 == MD_REMU) ? signA : (signA ^ signB);
                    opReg     <= isDiv ? magB : magA;
                    acc       <= {{XLEN{1'b0}}, (isDiv ? magA : magB)};
                    if (divZero)     result <= funct3[1] ? operandA : ALL_ONES;
                    else if (divOvf) result <= funct3[1] ? '0 : MIN_INT;
                end
                MD_CALC: begin
                    acc <= accNext;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) result <= calcResult;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == MD_CALC);
    assign done  = (state == MD_DONE);
    assign stall = start && !done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases, random
// operations against a plain-arithmetic reference, reset and back-to-back.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operandA, operandB;
    logic        busy, done, stall;
    logic [31:0] result;

    int nCompared   = 0;
    int nMismatched = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .funct3   (funct3),
        .operandA (operandA),
        .operandB (operandB),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            MD_MUL:    begin p = ua * ub; return p[31:0]; end
            MD_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            MD_MULHU:  begin p = ua * ub; return p[63:32]; end
            MD_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                q = sa / sb; return q[31:0];
            end
            MD_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
            MD_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues one op at a falling edge and follows it to DONE; operands are
    // scrambled during CALC to confirm they are ignored after acceptance.
    task automatic runOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit holdStart);
        int          lat, stallCnt;
        bit          busySeen, busyAndDone, special;
        logic [31:0] exp;
        string       tag;
        exp      = refModel(f3, a, b);
        special  = f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
        tag      = $sformatf("f3=%0d a=%h b=%h", f3, a, b);
        @(negedge clk);
        start = 1'b1; funct3 = f3; operandA = a; operandB = b;
        #1;
        stallCnt = int'(stall);
        lat = 0; busySeen = 0; busyAndDone = 0;
        while (lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (busy) busySeen = 1;
            if (busy && done) busyAndDone = 1;
            if (done) break;
            stallCnt += int'(stall);
            funct3 = 3'($urandom); operandA = $urandom; operandB = $urandom;
        end
        check({"done ", tag}, {31'd0, done}, 32'd1);
        check({"result ", tag}, result, exp);
        check({"latency ", tag}, lat, special ? 32'd1 : 32'd33);
        check({"stallCycles ", tag}, stallCnt, special ? 32'd1 : 32'd33);
        check({"stallInDone ", tag}, {31'd0, stall}, 32'd0);
        check({"busySeen ", tag}, {31'd0, busySeen}, {31'd0, !special});
        check({"busyAndDone ", tag}, {31'd0, busyAndDone}, 32'd0);
        if (!holdStart) start = 1'b0;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; funct3 = '0; operandA = '0; operandB = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;

        runOp(MD_MUL,    32'd7,        32'hFFFFFFFD, 0);
        runOp(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        runOp(MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        runOp(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        runOp(MD_DIV,    32'hFFFFFFF9, 32'd2,        0);
        runOp(MD_REM,    32'hFFFFFFF9, 32'd2,        0);
        runOp(MD_DIVU,   32'd100,      32'd7,        0);
        runOp(MD_REMU,   32'd100,      32'd7,        0);
        runOp(MD_DIV,    32'd5,        32'd0,        0);
        runOp(MD_REMU,   32'd5,        32'd0,        0);
        runOp(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 0);
        runOp(MD_REM,    32'h80000000, 32'hFFFFFFFF, 0);

        for (int i = 0; i < 48; i++) begin
            runOp(3'($urandom), pick(), pick(), 0);
        end

        // Asynchronous reset in the middle of a calculation.
        runOp(MD_MUL, 32'd7, 32'hFFFFFFFD, 0);
        @(negedge clk);
        start = 1'b1; funct3 = MD_DIVU; operandA = 32'hDEADBEEF; operandB = 32'd13;
        repeat (11) @(negedge clk);
        check("preReset busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midReset busy", {31'd0, busy}, 32'd0);
        check("midReset done", {31'd0, done}, 32'd0);
        check("midReset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp(MD_DIVU, 32'd9, 32'd3, 0);

        // Start held through DONE: one IDLE cycle, then a fresh calculation.
        runOp(MD_MUL, 32'd12345, 32'd678, 1);
        funct3 = MD_DIVU; operandA = 32'd1000; operandB = 32'd10;
        @(negedge clk);
        check("b2b idle busy", {31'd0, busy}, 32'd0);
        check("b2b idle done", {31'd0, done}, 32'd0);
        check("b2b idle stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        check("b2b calc busy", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b done", {31'd0, done}, 32'd1);
        check("b2b latency", lat, 32'd33);
        check("b2b result", result, refModel(MD_DIVU, 32'd1000, 32'd10));
        start = 1'b0;
        @(negedge clk);
        check("final idle busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the single-cycle core. It sits directly downstream of the register file. It takes the two register read ports as operands and returns a 32-bit result on the write-back path. While an M-extension instruction is in flight, it holds `stall` high so the core freezes the PC and suppresses `regWrite`.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported.

- `clk`  in  1: core clock, rising-edge state updates.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: current instruction is RV32M. Held high by the core until `done`.
- `funct3`  in  3: RV32M operation code. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `operandA`  in  XLEN: rs1 value from register file `readData1`.
- `operandB`  in  XLEN: rs2 value from register file `readData2`.
- `busy`  out  1: unit is in CALC.
- `done`  out  1: `result` valid this cycle, registered.
- `stall`  out  1: combinational, `start && !done`.
- `result`  out  XLEN: registered result, held until the next accepted start.

## Operation
- States:
  - IDLE: no operation in flight.
  - CALC: iterating, with 5-bit counter `cnt`.
  - DONE: result presented for one cycle.
- IDLE with `start` = 1, at the rising edge:
  - latch `funct3`, |A|, |B|, and the result sign;
  - `cnt` ← 0.
  - Special case, divide op with B = 0:
    - DIV/DIVU: `result` ← 0xFFFFFFFF;
    - REM/REMU: `result` ← A;
    - go to DONE.
  - Special case, DIV/REM with A = 0x80000000 and B = 0xFFFFFFFF:
    - DIV: `result` ← 0x80000000;
    - REM: `result` ← 0;
    - go to DONE.
  - Otherwise go to CALC.
- Operand signedness:
  - Both operands are signed for MULH, DIV and REM.
  - For MULHSU only A is signed.
  - MUL is treated as unsigned; the low word is the same either way.
  - Magnitude = two's-complement negate if signed and MSB = 1.
- Result sign:
  - Multiply: signA ^ signB.
  - Quotient: signA ^ signB.
  - Remainder: signA.
- CALC, multiply:
  - radix-2 shift-add into a 64-bit accumulator, one bit of |B| per cycle.
- CALC, divide:
  - restoring division, one quotient bit per cycle.
  - 32-bit remainder with a 33-bit trial subtract.
- CALC with `cnt` = 31 at the rising edge:
  - Apply the sign fix: negate the 64-bit product, or the quotient/remainder, if the sign bit is set.
  - Select the result field:
    - MUL: product[31:0];
    - MULH/MULHSU/MULHU: product[63:32];
    - DIV/DIVU: quotient;
    - REM/REMU: remainder.
  - Write `result` and go to DONE.
- DONE → IDLE unconditionally, even if `start` is still high.
  - The next M instruction therefore restarts from IDLE.
- `start` seen in CALC or DONE is not a new request.
  - Operand or `funct3` changes after acceptance are ignored.
- Reset, asynchronous, including mid-CALC:
  - state = IDLE, `cnt` = 0;
  - `busy` = 0, `done` = 0, `result` = 0;
  - all datapath registers = 0.
- Reset exit: first rising edge with `rst_n` = 1 may accept `start`.

## Timing
- Normal op:
  - `start` sampled at edge 0; `busy` = 1 from edge 0 to edge 32;
  - `done` = 1 for exactly one cycle, after edge 32;
  - latency 33 cycles; `stall` high for 33 cycles.
- Special case: `done` after edge 0 (latency 1); `busy` never asserts.
- `result` is stable in the DONE cycle.
  - The register file captures it on the falling edge of `clk` in that cycle.
  - The PC advances on the following rising edge.
- `busy` and `done` are never high together.
- Back-to-back M instructions: one IDLE cycle between DONE and the next CALC.
  - `stall` stays high during that IDLE cycle.

## Structure
- Package `muldiv_pkg` holds:
  - the `funct3` localparams (`MD_MUL` … `MD_REMU`);
  - the state encoding (`MD_IDLE`, `MD_CALC`, `MD_DONE`);
  - `XLEN`.
- Both the decoder and the unit import `muldiv_pkg`.
- One natural sub-module, `muldiv_step`: a combinational single iteration.
  - Inputs: accumulator, operand, divide/multiply select.
  - Outputs: the next accumulator/remainder/quotient bit.
- The FSM, counter, sign fix and result mux stay in `muldiv_unit`.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB, `done` exactly 33 cycles after `start`, `stall` high 33 cycles.
- A = B = 0xFFFFFFFF → MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
- Signed and unsigned divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF;
  - DIVU 100 / 7 → 14; REMU → 2.
- Divide by zero: DIV 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5, each with `done` one cycle after `start` and `busy` never high.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; both 1-cycle latency.
- Reset and back-to-back:
  - assert `rst_n` low at cycle 10 of CALC → `busy`/`done`/`result` are 0 immediately;
  - release, then issue DIVU 9 / 3 → 3 after 33 cycles;
  - hold `start` through DONE → exactly one IDLE cycle, then a new CALC begins.
